// File: rtl/alu_pkg.sv
// Shared opcode values and controller state encoding for the accumulator ALU.
package alu_pkg;
  localparam logic [3:0] MODE_ADD   = 4'd0;
  localparam logic [3:0] MODE_SUB   = 4'd1;
  localparam logic [3:0] MODE_AND   = 4'd2;
  localparam logic [3:0] MODE_OR    = 4'd3;
  localparam logic [3:0] MODE_XOR   = 4'd4;
  localparam logic [3:0] MODE_NOT   = 4'd5;
  localparam logic [3:0] MODE_INC   = 4'd6;
  localparam logic [3:0] MODE_DEC   = 4'd7;
  localparam logic [3:0] MODE_MUL   = 4'd8;
  localparam logic [3:0] MODE_SHL   = 4'd9;
  localparam logic [3:0] MODE_SHR   = 4'd10;
  localparam logic [3:0] MODE_PASSB = 4'd11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/alu_acc_seq_nbit_if.sv
// Command/result bundle between the decode stage (master) and the ALU (slave).
interface alu_acc_seq_nbit_if #(parameter int N = 8);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         CB_in;
  logic [3:0]   Mode;
  logic         use_acc;
  logic         acc_clr;
  logic         out_valid;
  logic [N-1:0] Result;
  logic [N-1:0] Result_hi;
  logic         CB_out;
  logic         Z;
  logic         Nf;
  logic         V;
  logic [N-1:0] acc;

  modport master (
    output in_valid, A, B, CB_in, Mode, use_acc, acc_clr,
    input  in_ready, out_valid, Result, Result_hi, CB_out, Z, Nf, V, acc
  );

  modport slave (
    input  in_valid, A, B, CB_in, Mode, use_acc, acc_clr,
    output in_ready, out_valid, Result, Result_hi, CB_out, Z, Nf, V, acc
  );
endinterface

// File: rtl/mul_shift_add_nbit.sv
// Unsigned shift-add multiplier: operands load on start, one partial-product
// step per clock, done pulses for one cycle after the N-th step.
module mul_shift_add_nbit #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int CW = $clog2(N) + 1;

  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand   <= {{N{1'b0}}, a};
        mplier  <= b;
        product <= '0;
        cnt     <= CW'(N);
        busy    <= 1'b1;
      end else if (busy) begin
        if (mplier[0])
          product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/alu_acc_seq_nbit.sv
// Handshaked N-bit ALU with accumulator and flags; single-cycle ops complete at
// the accept edge, MUL completes N+1 cycles later with in_ready held low.
module alu_acc_seq_nbit
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_acc_seq_nbit_if.slave bus
);
  state_t         state;
  logic [N-1:0]   a_eff;
  logic           accept;
  logic           mul_start;
  logic           mul_busy;
  logic           mul_done;
  logic [2*N-1:0] mul_prod;

  logic [N:0]     ext;
  logic [N-1:0]   r;
  logic           cb;
  logic           v;
  logic           ld_acc;

  assign a_eff     = bus.use_acc ? bus.acc : bus.A;
  assign accept    = (state == IDLE) && bus.in_valid && bus.in_ready;
  assign mul_start = accept && (bus.Mode == MODE_MUL);

  mul_shift_add_nbit #(.N(N)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a_eff),
    .b       (bus.B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    ext    = '0;
    r      = '0;
    cb     = 1'b0;
    v      = 1'b0;
    ld_acc = 1'b1;
    case (bus.Mode)
      MODE_ADD: begin
        ext = {1'b0, a_eff} + {1'b0, bus.B} + {{N{1'b0}}, bus.CB_in};
        r   = ext[N-1:0];
        cb  = ext[N];
        v   = (a_eff[N-1] == bus.B[N-1]) && (r[N-1] != a_eff[N-1]);
      end
      MODE_SUB: begin
        ext = {1'b0, a_eff} - {1'b0, bus.B};
        r   = ext[N-1:0];
        cb  = ext[N];
        v   = (a_eff[N-1] != bus.B[N-1]) && (r[N-1] != a_eff[N-1]);
      end
      MODE_AND:   r = a_eff & bus.B;
      MODE_OR:    r = a_eff | bus.B;
      MODE_XOR:   r = a_eff ^ bus.B;
      MODE_NOT:   r = ~a_eff;
      MODE_INC: begin
        ext = {1'b0, a_eff} + (N+1)'(1);
        r   = ext[N-1:0];
        cb  = ext[N];
        v   = !a_eff[N-1] && r[N-1];
      end
      MODE_DEC: begin
        ext = {1'b0, a_eff} - (N+1)'(1);
        r   = ext[N-1:0];
        cb  = ext[N];
        v   = a_eff[N-1] && !r[N-1];
      end
      MODE_SHL: begin
        r  = {a_eff[N-2:0], 1'b0};
        cb = a_eff[N-1];
      end
      MODE_SHR: begin
        r  = {1'b0, a_eff[N-1:1]};
        cb = a_eff[0];
      end
      MODE_PASSB: r = bus.B;
      // MUL results come from the multiplier; reserved codes leave acc alone.
      default:    ld_acc = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.Result    <= '0;
      bus.Result_hi <= '0;
      bus.CB_out    <= 1'b0;
      bus.Z         <= 1'b0;
      bus.Nf        <= 1'b0;
      bus.V         <= 1'b0;
      bus.acc       <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (accept) begin
            if (bus.Mode == MODE_MUL) begin
              state        <= BUSY;
              bus.in_ready <= 1'b0;
            end else begin
              bus.out_valid <= 1'b1;
              bus.Result    <= r;
              bus.Result_hi <= '0;
              bus.CB_out    <= cb;
              bus.Z         <= (r == '0);
              bus.Nf        <= r[N-1];
              bus.V         <= v;
              if (ld_acc)
                bus.acc <= r;
            end
          end
        end
        BUSY: begin
          if (mul_done && !mul_busy) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.Result    <= mul_prod[N-1:0];
            bus.Result_hi <= mul_prod[2*N-1:N];
            bus.CB_out    <= 1'b0;
            bus.Z         <= (mul_prod == '0);
            bus.Nf        <= mul_prod[2*N-1];
            bus.V         <= 1'b0;
            bus.acc       <= mul_prod[N-1:0];
          end
        end
        DONE: begin
          state        <= IDLE;
          bus.in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (bus.acc_clr)
        bus.acc <= '0;
    end
  end
endmodule

// File: tb/tb_alu_acc_seq_nbit.sv
// Directed bench for alu_acc_seq_nbit at N=8: vector table plus MUL, accumulator
// and reset sequences.
module tb_alu_acc_seq_nbit;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_acc_seq_nbit_if #(.N(8)) bus ();

  alu_acc_seq_nbit #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] r;
    logic       cb;
    logic       z;
    logic       n;
    logic       v;
    logic [7:0] acc;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic op(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b,
                    input logic ci, input logic ua, input logic clr);
    @(negedge clk);
    bus.Mode     = m;
    bus.A        = a;
    bus.B        = b;
    bus.CB_in    = ci;
    bus.use_acc  = ua;
    bus.acc_clr  = clr;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.acc_clr  = 1'b0;
    bus.use_acc  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_result"},    32'(bus.Result),    0);
    chk({tag, "_result_hi"}, 32'(bus.Result_hi), 0);
    chk({tag, "_cb"},        32'(bus.CB_out),    0);
    chk({tag, "_z"},         32'(bus.Z),         0);
    chk({tag, "_nf"},        32'(bus.Nf),        0);
    chk({tag, "_v"},         32'(bus.V),         0);
    chk({tag, "_acc"},       32'(bus.acc),       0);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int cyc;
    checks = 0;
    errors = 0;

    //         mode        a      b      ci    r      cb    z     n     v     acc
    vecs[0]  = '{MODE_ADD,   8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01};
    vecs[1]  = '{MODE_ADD,   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 8'h80};
    vecs[2]  = '{MODE_SUB,   8'h05, 8'h07, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFE};
    vecs[3]  = '{MODE_SUB,   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 8'h7F};
    vecs[4]  = '{MODE_AND,   8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 8'h30};
    vecs[5]  = '{MODE_OR,    8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF};
    vecs[6]  = '{MODE_XOR,   8'hAA, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{MODE_NOT,   8'h0F, 8'h00, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0};
    vecs[8]  = '{MODE_INC,   8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{MODE_INC,   8'h7F, 8'h00, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 8'h80};
    vecs[10] = '{MODE_DEC,   8'h00, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF};
    vecs[11] = '{MODE_DEC,   8'h80, 8'h00, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 8'h7F};
    vecs[12] = '{MODE_SHL,   8'h81, 8'h00, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02};
    vecs[13] = '{MODE_SHR,   8'h81, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 8'h40};
    vecs[14] = '{MODE_PASSB, 8'h11, 8'h5A, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A};
    vecs[15] = '{4'd12,      8'h33, 8'h44, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A};

    bus.in_valid = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.CB_in    = 1'b0;
    bus.Mode     = '0;
    bus.use_acc  = 1'b0;
    bus.acc_clr  = 1'b0;
    rst          = 1'b1;
    #1;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    chk("reset_held_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release_in_ready_before_edge", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    chk("release_in_ready", 32'(bus.in_ready), 1);

    // Back-to-back single-cycle table.
    for (int i = 0; i < 16; i++) begin
      op(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0, 1'b0);
      chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 1);
      chk($sformatf("vec%0d_in_ready", i),  32'(bus.in_ready),  1);
      chk($sformatf("vec%0d_result", i),    32'(bus.Result),    32'(vecs[i].r));
      chk($sformatf("vec%0d_result_hi", i), 32'(bus.Result_hi), 0);
      chk($sformatf("vec%0d_cb", i),        32'(bus.CB_out),    32'(vecs[i].cb));
      chk($sformatf("vec%0d_z", i),         32'(bus.Z),         32'(vecs[i].z));
      chk($sformatf("vec%0d_nf", i),        32'(bus.Nf),        32'(vecs[i].n));
      chk($sformatf("vec%0d_v", i),         32'(bus.V),         32'(vecs[i].v));
      chk($sformatf("vec%0d_acc", i),       32'(bus.acc),       32'(vecs[i].acc));
    end
    idle();
    chk("table_out_valid_drop", 32'(bus.out_valid), 0);
    chk("table_result_hold",    32'(bus.Result),    0);
    chk("table_z_hold",         32'(bus.Z),         1);

    // MUL FF*FF with an ignored in_valid pulse while busy.
    op(MODE_MUL, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("mul_accept_in_ready", 32'(bus.in_ready), 0);
    chk("mul_accept_out_valid", 32'(bus.out_valid), 0);
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.in_valid = (k == 4);
      bus.Mode     = MODE_ADD;
      bus.A        = 8'h01;
      bus.B        = 8'h01;
      @(posedge clk);
      #1;
      chk($sformatf("mul_cyc%0d_in_ready", k), 32'(bus.in_ready), 0);
      if (bus.out_valid) begin
        cyc = k;
        break;
      end
    end
    chk("mul_latency",   32'(cyc),           9);
    chk("mul_result",    32'(bus.Result),    32'h01);
    chk("mul_result_hi", 32'(bus.Result_hi), 32'hFE);
    chk("mul_z",         32'(bus.Z),         0);
    chk("mul_nf",        32'(bus.Nf),        1);
    chk("mul_cb",        32'(bus.CB_out),    0);
    chk("mul_v",         32'(bus.V),         0);
    chk("mul_acc",       32'(bus.acc),       32'h01);
    idle();
    chk("mul_done_in_ready",  32'(bus.in_ready),  1);
    chk("mul_done_out_valid", 32'(bus.out_valid), 0);
    idle();
    chk("mul_no_ghost_add", 32'(bus.out_valid), 0);
    chk("mul_result_hold",  32'(bus.Result_hi), 32'hFE);

    // Accumulator chaining.
    @(negedge clk);
    bus.acc_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("acc_clr", 32'(bus.acc), 0);
    chk("acc_clr_no_result_change", 32'(bus.Result), 32'h01);
    for (int k = 1; k <= 3; k++) begin
      op(MODE_INC, 8'hEE, 8'h00, 1'b0, 1'b1, 1'b0);
      chk($sformatf("inc_chain%0d_acc", k),    32'(bus.acc),    32'(k));
      chk($sformatf("inc_chain%0d_result", k), 32'(bus.Result), 32'(k));
    end
    idle();
    @(negedge clk);
    bus.acc_clr = 1'b1;
    @(posedge clk);
    #1;
    op(MODE_DEC, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("dec_acc0_result", 32'(bus.Result), 32'hFF);
    chk("dec_acc0_cb",     32'(bus.CB_out), 1);
    chk("dec_acc0_acc",    32'(bus.acc),    32'hFF);

    // acc_clr wins over a same-cycle completion.
    op(MODE_ADD, 8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
    chk("clr_add_acc",    32'(bus.acc),       0);
    chk("clr_add_result", 32'(bus.Result),    32'h30);
    chk("clr_add_valid",  32'(bus.out_valid), 1);

    // Load nonzero state, then reset four cycles into a MUL.
    op(MODE_PASSB, 8'h00, 8'h97, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_acc", 32'(bus.acc), 32'h97);
    op(MODE_MUL, 8'h03, 8'h04, 1'b0, 1'b0, 1'b0);
    idle();
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk_all_zero("mid_mul_rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);
    op(MODE_ADD, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0);
    chk("post_rst_add_valid",  32'(bus.out_valid), 1);
    chk("post_rst_add_result", 32'(bus.Result),    32'h05);
    chk("post_rst_add_acc",    32'(bus.acc),       32'h05);
    idle();
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_quiet%0d", k), 32'(bus.out_valid), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
